// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmitter.
// The PARITY state is only present when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int STOP_BITS_DEFAULT  = 1;

  typedef logic [15:0] timer_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_shreg.sv
// Parallel-load, shift-right data register feeding the serial line, LSB first.
module uart_tx_shreg
  import uart_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit0_o,
  output logic             bit1_o
);

  logic [WIDTH-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = shreg_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign bit0_o = shreg_q[0];

  // bit1 is the value bit0 takes after a shift; lets the line register look one bit ahead.
  generate
    if (WIDTH > 1) begin : g_bit1
      assign bit1_o = shreg_q[1];
    end else begin : g_no_bit1
      assign bit1_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, DATA_WIDTH data bits LSB first, optional even parity
// (macro UART_PARITY_EN), STOP_BITS stop bits; bit timing comes from an external baud counter.
//
// state  | meaning
// IDLE   | line high, counter held clear, waiting for tx_start
// START  | driving the start bit (low)
// DATA   | driving data bits from the shift register
// PARITY | driving the even-parity bit (UART_PARITY_EN only)
// STOP   | driving stop bit(s) high; last tick ends the frame
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int STOP_BITS  = STOP_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  baud_en,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  uart_tx_state_t   state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             stop_idx_q, stop_idx_d;
  logic             tx_serial_q, tx_serial_d;
  logic             tx_done_q, tx_done_d;
  logic             load, shift;
  logic             sh_bit0, sh_bit1;
`ifdef UART_PARITY_EN
  logic             parity_q, parity_d;
`endif

  uart_tx_shreg #(.WIDTH(DATA_WIDTH)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (tx_data),
    .bit0_o  (sh_bit0),
    .bit1_o  (sh_bit1)
  );

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    tx_done_d  = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
`ifdef UART_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          load       = 1'b1;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          state_d    = START;
`ifdef UART_PARITY_EN
          parity_d   = ^tx_data;
`endif
        end
      end
      START: begin
        if (baud_tick) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift = 1'b1;
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
`ifdef UART_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          if (stop_idx_q == LAST_STOP) begin
            stop_idx_d = 1'b0;
            tx_done_d  = 1'b1;
            state_d    = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so it changes with the state, not a cycle later.
    case (state_d)
      START:   tx_serial_d = 1'b0;
      DATA:    tx_serial_d = shift ? sh_bit1 : sh_bit0;
`ifdef UART_PARITY_EN
      PARITY:  tx_serial_d = parity_q;
`endif
      default: tx_serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      tx_serial_q <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      tx_serial_q <= tx_serial_d;
      tx_done_q   <= tx_done_d;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign baud_en   = (state_q != IDLE);
  assign tx_busy   = (state_q != IDLE);
  assign tx_serial = tx_serial_q;
  assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two instances (1 and 2 stop bits), each fed by a baud counter model.
`timescale 1ns/1ps
module tb_uart_tx_frame;
  import uart_pkg::*;

`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  typedef struct {
    int          dut;
    int          k;
    int          n;
    int          nbits;
    logic [15:0] bits;
    int          done_off;
  } frame_t;

  typedef struct {
    int          dut;
    int          n;
    logic [7:0]  data;
    int          nbits;
    logic [15:0] bits;
    int          done_off;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start;
  logic [1:0] tick;
  logic [1:0] inj;
  logic [1:0] baud_en;
  logic [1:0] tx_serial;
  logic [1:0] tx_busy;
  logic [1:0] tx_done;
  logic [7:0] data [2];
  timer_t     cnt [2];
  timer_t     n_cur;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;
  frame_t     sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst || !baud_en[d]) cnt[d] <= '0;
      else if (cnt[d] == n_cur - 16'd1) cnt[d] <= '0;
      else cnt[d] <= cnt[d] + 16'd1;
    end
  end

  assign tick[0] = inj[0] | (baud_en[0] & (cnt[0] == n_cur - 16'd1));
  assign tick[1] = inj[1] | (baud_en[1] & (cnt[1] == n_cur - 16'd1));

  uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .baud_tick(tick[0]), .tx_start(start[0]), .tx_data(data[0]),
    .baud_en(baud_en[0]), .tx_serial(tx_serial[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

  uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .baud_tick(tick[1]), .tx_start(start[1]), .tx_data(data[1]),
    .baud_en(baud_en[1]), .tx_serial(tx_serial[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

  task automatic chk(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, d, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  function automatic logic [15:0] frame_bits(input logic [7:0] v);
    logic [15:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = v[i];
    if (P == 1) b[9] = ^v;
    return b;
  endfunction

  function automatic bit dut_idle(input int d);
    int nf;
    int last;
    nf = 0;
    last = 0;
    foreach (sb[i]) begin
      if (sb[i].dut == d) begin
        nf++;
        last = sb[i].k + sb[i].done_off;
      end
    end
    return (nf == 0) || (nf == 1 && cyc == last);
  endfunction

  // Scoreboard monitor: each cycle compares the line against the oldest pending frame.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        int fi;
        int t;
        fi = -1;
        for (int i = 0; i < sb.size(); i++) if (fi < 0 && sb[i].dut == d) fi = i;
        t = (fi >= 0) ? cyc - sb[fi].k : 0;
        if (fi >= 0 && t >= 1 && t < sb[fi].done_off) begin
          chk("serial", d, 16'(tx_serial[d]), 16'(sb[fi].bits[(t-1)/sb[fi].n]));
          chk("busy", d, 16'(tx_busy[d]), 16'd1);
          chk("baud_en", d, 16'(baud_en[d]), 16'd1);
          chk("done_early", d, 16'(tx_done[d]), 16'd0);
        end else if (fi >= 0 && t >= sb[fi].done_off) begin
          chk("done", d, 16'(tx_done[d]), 16'd1);
          chk("busy_at_done", d, 16'(tx_busy[d]), 16'd0);
          chk("serial_at_done", d, 16'(tx_serial[d]), 16'd1);
          sb.delete(fi);
        end else begin
          chk("idle_serial", d, 16'(tx_serial[d]), 16'd1);
          chk("idle_busy", d, 16'(tx_busy[d]), 16'd0);
          chk("idle_baud_en", d, 16'(baud_en[d]), 16'd0);
          chk("idle_done", d, 16'(tx_done[d]), 16'd0);
        end
      end
    end
  end

  task automatic send(input int d, input logic [7:0] v, input int nbits,
                      input logic [15:0] bits, input int done_off, output int k);
    frame_t f;
    int w;
    w = 0;
    while (!dut_idle(d) && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 2000) timeout("send_wait");
    start[d] = 1'b1;
    data[d]  = v;
    k = cyc;
    f = '{d, cyc, int'(n_cur), nbits, bits, done_off};
    sb.push_back(f);
    @(posedge clk); #1;
    start[d] = 1'b0;
    data[d]  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 2000) begin
      timeout("frame_end");
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  vec_t vt[4];
  int   k;
  int   nb;
  int   doff;

  initial begin
`ifdef UART_PARITY_EN
    vt[0] = '{0, 4, 8'hA5, 11, 16'b10101001010, 45};
    vt[1] = '{0, 4, 8'h07, 11, 16'b11000001110, 45};
    vt[2] = '{0, 4, 8'h03, 11, 16'b10000000110, 45};
    vt[3] = '{1, 3, 8'hA5, 12, 16'b110101001010, 37};
`else
    vt[0] = '{0, 4, 8'hA5, 10, 16'b1101001010, 41};
    vt[1] = '{0, 4, 8'h07, 10, 16'b1000001110, 41};
    vt[2] = '{0, 4, 8'h03, 10, 16'b1000000110, 41};
    vt[3] = '{1, 3, 8'hA5, 11, 16'b11101001010, 34};
`endif

    rst = 1'b0;
    start = '0;
    inj = '0;
    data[0] = '0;
    data[1] = '0;
    n_cur = 16'd4;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_serial", d, 16'(tx_serial[d]), 16'd1);
      chk("rst_busy", d, 16'(tx_busy[d]), 16'd0);
      chk("rst_baud_en", d, 16'(baud_en[d]), 16'd0);
      chk("rst_done", d, 16'(tx_done[d]), 16'd0);
    end
    rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Stray ticks while idle must not start anything.
    inj = 2'b11;
    @(posedge clk); #1;
    inj = 2'b00;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      n_cur = timer_t'(vt[i].n);
      send(vt[i].dut, vt[i].data, vt[i].nbits, vt[i].bits, vt[i].done_off, k);
      wait_idle();
    end

    // tx_start with new data during an 8'h00 frame is ignored.
    n_cur = 16'd4;
    nb = 10 + P;
    doff = 4 * nb + 1;
    send(0, 8'h00, nb, frame_bits(8'h00), doff, k);
    repeat (10) @(posedge clk);
    #1;
    start[0] = 1'b1;
    data[0]  = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);
    #1;

    // Back-to-back with tx_start held high: 8'h55 then 8'hAA.
    n_cur = 16'd2;
    doff = 2 * nb + 1;
    start[0] = 1'b1;
    data[0]  = 8'h55;
    k = cyc;
    sb.push_back('{0, cyc, 2, nb, frame_bits(8'h55), doff});
    @(posedge clk); #1;
    data[0] = 8'hAA;
    while (cyc < k + doff) begin
      @(posedge clk); #1;
    end
    sb.push_back('{0, cyc, 2, nb, frame_bits(8'hAA), doff});
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_idle();

    // Reset during the 4th data bit aborts the frame; a following frame is intact.
    n_cur = 16'd4;
    doff = 4 * nb + 1;
    send(0, 8'h3C, nb, frame_bits(8'h3C), doff, k);
    while (cyc < k + 18) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    rst = 1'b1;
    chk("abort_serial", 0, 16'(tx_serial[0]), 16'd1);
    chk("abort_busy", 0, 16'(tx_busy[0]), 16'd0);
    chk("abort_baud_en", 0, 16'(baud_en[0]), 16'd0);
    chk("abort_done", 0, 16'(tx_done[0]), 16'd0);
    repeat (20) @(posedge clk);
    #1;
    send(0, 8'hC3, nb, frame_bits(8'hC3), doff, k);
    wait_idle();
    repeat (5) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
